controller_l2: RTL and testbench

//  Sequencer for the layer-2 convolution datapath: drives filter-load, line-buffer fill, window, MAC, accumulate and OFM-write strobes.

---
 rtl/ctrl_l2_pkg.sv | 43 ++++
 rtl/controller_l2_stage_counter.sv | 35 +++
 rtl/controller_l2.sv | 179 +++++++++++++++++
 tb/tb_controller_l2.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/ctrl_l2_pkg.sv
// rtl/ctrl_l2_pkg.sv - shared types and sizes for the layer-2 convolution sequencer
// Contents: FSM state encoding, counter widths, default loop sizes and the
//   packed bundle of registered controller outputs.
package ctrl_l2_pkg;

  localparam int CNT_W  = 6;   // filter, line-buffer and MAC step counters
  localparam int ADDR_W = 8;   // ifm read address and output pixel index

  localparam int DEF_FILT_WORDS = 4;
  localparam int DEF_BUFF_DEPTH = 64;
  localparam int DEF_MAC_STEPS  = 16;
  localparam int DEF_OFM_SIZE   = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILT  = 3'd1,
    ST_BUFF  = 3'd2,
    ST_WRST  = 3'd3,
    ST_WLOAD = 3'd4,
    ST_MAC   = 3'd5,
    ST_WR    = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              ifm_rd;
    logic [ADDR_W-1:0] ifm_addr;
    logic [3:0]        w_en_filter;
    logic [CNT_W-1:0]  filter_count;
    logic              w_en_buff;
    logic [CNT_W-1:0]  buff_address;
    logic              win_rst;
    logic              write_en_window;
    logic              read_en_mac;
    logic              add_en;
    logic [CNT_W-1:0]  mac_count;
    logic              wr_ofm;
    logic [ADDR_W-1:0] ofm_addr;
  } ctrl_out_t;

endpackage

// File: rtl/controller_l2_stage_counter.sv
// rtl/controller_l2_stage_counter.sv - loop counter with clear, enable and terminal-count flag
// Ports: clk, rst (async active-low), clr (sync load-zero, wins over en), en,
//   last_val (terminal value), count (current), count_next (value after this edge),
//   tc (count == last_val). The counter wraps to 0 when enabled at terminal count.
module stage_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] last_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next,
  output logic             tc
);

  assign tc = (count == last_val);

  always_comb begin
    count_next = count;
    if (clr)
      count_next = '0;
    else if (en)
      count_next = tc ? '0 : count + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else
      count <= count_next;
  end

endmodule

// File: rtl/controller_l2.sv
// rtl/controller_l2.sv - layer-2 convolution sequencer (filter load, line fill, window/MAC/write loop)
// Ports: clk, rst (async active-low), start, abort; outputs busy, done, ifm_rd, ifm_addr,
//   wEnFilter, filterCount, wEnBuff, buffAddress, winRst, writeEnwindow, readEnmac,
//   addEn, macCount, wrofm, ofmaddr; perf_cycles when CTRL_L2_PERF_CNT_EN is defined.
// All outputs come straight from flops; they are computed from the next state and
// next counter values so they line up with the state they describe.
module controller_l2
  import ctrl_l2_pkg::*;
#(
  parameter int FILT_WORDS = DEF_FILT_WORDS,
  parameter int BUFF_DEPTH = DEF_BUFF_DEPTH,
  parameter int MAC_STEPS  = DEF_MAC_STEPS,
  parameter int OFM_SIZE   = DEF_OFM_SIZE
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CTRL_L2_PERF_CNT_EN
  output logic [15:0]       perf_cycles,
`endif
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              ifm_rd,
  output logic [ADDR_W-1:0] ifm_addr,
  output logic [3:0]        wEnFilter,
  output logic [CNT_W-1:0]  filterCount,
  output logic              wEnBuff,
  output logic [CNT_W-1:0]  buffAddress,
  output logic              winRst,
  output logic              writeEnwindow,
  output logic              readEnmac,
  output logic              addEn,
  output logic [CNT_W-1:0]  macCount,
  output logic              wrofm,
  output logic [ADDR_W-1:0] ofmaddr
);

  state_t state, state_next;
  logic   clr_all, k_en, j_en, m_en, o_en;
  logic   k_tc, j_tc, m_tc, o_tc;
  logic [CNT_W-1:0]  k_cnt, k_nxt, j_cnt, j_nxt, m_cnt, m_nxt;
  logic [ADDR_W-1:0] o_cnt, o_nxt;
  ctrl_out_t out_d, out_q;

  stage_counter #(.WIDTH(CNT_W)) u_filt_cnt (
    .clk(clk), .rst(rst), .clr(clr_all), .en(k_en), .last_val(CNT_W'(FILT_WORDS - 1)),
    .count(k_cnt), .count_next(k_nxt), .tc(k_tc));
  stage_counter #(.WIDTH(CNT_W)) u_buff_cnt (
    .clk(clk), .rst(rst), .clr(clr_all), .en(j_en), .last_val(CNT_W'(BUFF_DEPTH - 1)),
    .count(j_cnt), .count_next(j_nxt), .tc(j_tc));
  stage_counter #(.WIDTH(CNT_W)) u_mac_cnt (
    .clk(clk), .rst(rst), .clr(clr_all), .en(m_en), .last_val(CNT_W'(MAC_STEPS - 1)),
    .count(m_cnt), .count_next(m_nxt), .tc(m_tc));
  stage_counter #(.WIDTH(ADDR_W)) u_ofm_cnt (
    .clk(clk), .rst(rst), .clr(clr_all), .en(o_en), .last_val(ADDR_W'(OFM_SIZE - 1)),
    .count(o_cnt), .count_next(o_nxt), .tc(o_tc));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    clr_all    = 1'b0;
    k_en       = 1'b0;
    j_en       = 1'b0;
    m_en       = 1'b0;
    o_en       = 1'b0;
    case (state)
      ST_IDLE: begin
        clr_all = 1'b1;
        if (start) state_next = ST_FILT;
      end
      ST_FILT: begin
        k_en = 1'b1;
        if (k_tc) state_next = ST_BUFF;
      end
      ST_BUFF: begin
        j_en = 1'b1;
        if (j_tc) state_next = ST_WRST;
      end
      ST_WRST:  state_next = ST_WLOAD;
      ST_WLOAD: state_next = ST_MAC;
      ST_MAC: begin
        m_en = 1'b1;
        if (m_tc) state_next = ST_WR;
      end
      ST_WR: begin
        o_en       = 1'b1;
        state_next = o_tc ? ST_DONE : ST_WRST;
      end
      ST_DONE: begin
        clr_all    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // Abort overrides every stage transition, including the final WR.
    if (abort && state != ST_IDLE && state != ST_DONE) begin
      state_next = ST_IDLE;
      clr_all    = 1'b1;
    end
  end

  always_comb begin
    out_d      = '0;
    out_d.busy = (state_next != ST_IDLE) && (state_next != ST_DONE);
    case (state_next)
      ST_FILT: begin
        out_d.ifm_rd       = 1'b1;
        out_d.ifm_addr     = ADDR_W'(k_nxt);
        out_d.w_en_filter  = 4'b1111;
        out_d.filter_count = k_nxt;
      end
      ST_BUFF: begin
        out_d.ifm_rd       = 1'b1;
        out_d.ifm_addr     = ADDR_W'(FILT_WORDS + int'(j_nxt));
        out_d.w_en_buff    = 1'b1;
        out_d.buff_address = j_nxt;
      end
      ST_WRST:  out_d.win_rst = 1'b1;
      ST_WLOAD: begin
        out_d.write_en_window = 1'b1;
        out_d.buff_address    = CNT_W'(int'(o_nxt) % BUFF_DEPTH);
      end
      ST_MAC: begin
        out_d.read_en_mac = 1'b1;
        out_d.add_en      = 1'b1;
        out_d.mac_count   = m_nxt;
      end
      ST_WR: begin
        out_d.wr_ofm   = 1'b1;
        out_d.ofm_addr = o_nxt;
      end
      ST_DONE: out_d.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      out_q <= '0;
    else
      out_q <= out_d;
  end

  assign busy          = out_q.busy;
  assign done          = out_q.done;
  assign ifm_rd        = out_q.ifm_rd;
  assign ifm_addr      = out_q.ifm_addr;
  assign wEnFilter     = out_q.w_en_filter;
  assign filterCount   = out_q.filter_count;
  assign wEnBuff       = out_q.w_en_buff;
  assign buffAddress   = out_q.buff_address;
  assign winRst        = out_q.win_rst;
  assign writeEnwindow = out_q.write_en_window;
  assign readEnmac     = out_q.read_en_mac;
  assign addEn         = out_q.add_en;
  assign macCount      = out_q.mac_count;
  assign wrofm         = out_q.wr_ofm;
  assign ofmaddr       = out_q.ofm_addr;

`ifdef CTRL_L2_PERF_CNT_EN
  // Counts cycles with busy asserted; cleared when a start is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      perf_cycles <= '0;
    else if (state == ST_IDLE && start)
      perf_cycles <= '0;
    else if (out_q.busy && perf_cycles != 16'hFFFF)
      perf_cycles <= perf_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_controller_l2.sv
// tb/tb_controller_l2.sv - directed self-checking bench for controller_l2
module tb_controller_l2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, ifm_rd, wEnBuff, winRst, writeEnwindow, readEnmac, addEn, wrofm;
  logic [7:0] ifm_addr, ofmaddr;
  logic [3:0] wEnFilter;
  logic [5:0] filterCount, buffAddress, macCount;
`ifdef CTRL_L2_PERF_CNT_EN
  logic [15:0] perf_cycles;
`endif

  int total = 0;
  int bad   = 0;

  controller_l2 dut (
    .clk(clk), .rst(rst),
`ifdef CTRL_L2_PERF_CNT_EN
    .perf_cycles(perf_cycles),
`endif
    .start(start), .abort(abort), .busy(busy), .done(done),
    .ifm_rd(ifm_rd), .ifm_addr(ifm_addr), .wEnFilter(wEnFilter), .filterCount(filterCount),
    .wEnBuff(wEnBuff), .buffAddress(buffAddress), .winRst(winRst),
    .writeEnwindow(writeEnwindow), .readEnmac(readEnmac), .addEn(addEn),
    .macCount(macCount), .wrofm(wrofm), .ofmaddr(ofmaddr));

  always #5 clk = ~clk;

  logic [46:0] obs;
  assign obs = {busy, done, ifm_rd, ifm_addr, wEnFilter, filterCount, wEnBuff, buffAddress,
                winRst, writeEnwindow, readEnmac, addEn, macCount, wrofm, ofmaddr};

  // Expected outputs for busy cycle c of a pass (c=0 is the first FILT cycle).
  function automatic logic [46:0] exp_vec(input int c);
    logic b, d, rd, wb, wrs, wl, rm, ae, wo;
    logic [7:0] ia, oa;
    logic [3:0] wf;
    logic [5:0] fc, ba, mc;
    int r, o, p;
    {b, d, rd, wb, wrs, wl, rm, ae, wo} = '0;
    ia = '0; oa = '0; wf = '0; fc = '0; ba = '0; mc = '0;
    if (c < 4) begin
      b = 1'b1; rd = 1'b1; ia = 8'(c); wf = 4'hF; fc = 6'(c);
    end else if (c < 68) begin
      b = 1'b1; rd = 1'b1; ia = 8'(c); wb = 1'b1; ba = 6'(c - 4);
    end else if (c < 4932) begin
      r = c - 68; o = r / 19; p = r % 19;
      b = 1'b1;
      if (p == 0) wrs = 1'b1;
      else if (p == 1) begin wl = 1'b1; ba = 6'(o % 64); end
      else if (p < 18) begin rm = 1'b1; ae = 1'b1; mc = 6'(p - 2); end
      else begin wo = 1'b1; oa = 8'(o); end
    end else if (c == 4932) begin
      d = 1'b1;
    end
    return {b, d, rd, ia, wf, fc, wb, ba, wrs, wl, rm, ae, mc, wo, oa};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Entered at the negedge showing cycle c0; leaves at the negedge showing c1+1.
  task automatic check_cycles(input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      chk($sformatf("trace_c%0d", c), 64'(obs), 64'(exp_vec(c)));
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(obs), 64'd0);
`ifdef CTRL_L2_PERF_CNT_EN
    chk("reset_perf", 64'(perf_cycles), 64'd0);
`endif
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_release", 64'(obs), 64'd0);

    // Pass 1: start with abort together in IDLE (start wins); full trace incl. done and return to IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_cycles(0, 4933);
`ifdef CTRL_L2_PERF_CNT_EN
    chk("perf_full_pass", 64'(perf_cycles), 64'd4932);
`endif

    // Abort in IDLE has no effect
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_in_idle", 64'(obs), 64'd0);

    // Pass 2: abort during MAC of o=10 (m=5 visible at c=265)
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_cycles(0, 264);
    chk("mac_o10_m5", 64'(obs), 64'(exp_vec(265)));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_to_idle", 64'(obs), 64'd0);
`ifdef CTRL_L2_PERF_CNT_EN
    chk("perf_after_abort", 64'(perf_cycles), 64'd266);
`endif
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("no_wr_no_done_after_abort", 64'({wrofm, done, busy}), 64'd0);
    end

    // Pass 3: asynchronous reset during BUFF j=30 (c=34)
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_cycles(0, 33);
    chk("buff_j30", 64'(obs), 64'(exp_vec(34)));
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", 64'(obs), 64'd0);
`ifdef CTRL_L2_PERF_CNT_EN
    chk("async_reset_perf", 64'(perf_cycles), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Pass 4: start held high throughout; restart only after returning to IDLE
    start = 1'b1;
    @(negedge clk);
    check_cycles(0, 4932);
`ifdef CTRL_L2_PERF_CNT_EN
    chk("perf_start_held", 64'(perf_cycles), 64'd4932);
`endif
    check_cycles(4933, 4933);
    start = 1'b0;
    check_cycles(0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
